// File: rtl/pipe_cla_addsub.sv
// ---------------------------------------------------------------------------
// pipe_cla_addsub
//
// Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready
// handshake on both sides. Stage 1 conditions operand B for subtraction,
// forms per-bit propagate/generate and per-block group propagate/generate.
// Stage 2 resolves every block carry-in directly from the registered group
// terms (two-level lookahead, no ripple between blocks), forms the in-block
// sums and registers the result together with its status flags.
//
// The pipeline holds at most two operations. A result appears after the
// second rising edge, counting the edge that accepts the operands. One
// operation per cycle is sustained while the consumer keeps out_ready high.
//
// Optional build macro:
//   PIPE_CLA_SATURATE_EN - when defined, a signed overflow clamps the sum
//                          toward the sign of operand A. carryout and
//                          overflow still describe the unclamped result,
//                          and zero describes the clamped sum.
//
// Parameters:
//   WIDTH  operand/result width, a multiple of BLOCK
//   BLOCK  bits per lookahead block, WIDTH/BLOCK in 2..8
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   in_valid       operand set presented
//   in_ready       block can accept an operand set this cycle
//   op             00 ADD, 01 SUB, 10 ADC, 11 SBC
//   data_operandA  operand A
//   data_operandB  operand B
//   carryin        carry in, used by ADC/SBC only
//   out_valid      result valid
//   out_ready      consumer accepts the result
//   sum            result
//   carryout       carry out of the MSB (1 = no borrow for SUB/SBC)
//   overflow       signed overflow
//   zero           sum equals zero
// ---------------------------------------------------------------------------
module pipe_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NB = WIDTH / BLOCK;

    // Stage 1 state
    logic             r_s1Valid;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;
    logic [WIDTH-1:0] r_s1P;
    logic [WIDTH-1:0] r_s1G;
    logic             r_s1Cin;
    logic [NB-1:0]    r_s1GrpP;
    logic [NB-1:0]    r_s1GrpG;

    // Stage 2 state
    logic             r_s2Valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Combinational nets
    logic [WIDTH-1:0] w_bEff;
    logic             w_cinEff;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NB-1:0]    w_grpP;
    logic [NB-1:0]    w_grpG;
    logic [NB:0]      w_blkCarry;
    logic             w_term;
    logic [WIDTH-1:0] w_bitCarry;
    logic [WIDTH-1:0] w_sumRaw;
    logic [WIDTH-1:0] w_sumFinal;
    logic             w_msbCout;
    logic             w_ovf;
    logic             w_s2Adv;

    // Stage 2 moves when it is empty or its result is being taken; stage 1
    // can then always accept, because its current content moves with it.
    assign w_s2Adv  = !r_s2Valid || out_ready;
    assign in_ready = !r_s1Valid || w_s2Adv;

    // Operand conditioning: subtraction inverts B, and the carry-in is
    // forced for ADD/SUB so only ADC/SBC look at carryin.
    always_comb begin
        w_bEff = op[0] ? ~data_operandB : data_operandB;
        case (op)
            2'b00:   w_cinEff = 1'b0;
            2'b01:   w_cinEff = 1'b1;
            default: w_cinEff = carryin;
        endcase
        w_p = data_operandA | w_bEff;
        w_g = data_operandA & w_bEff;
    end

    // Group propagate/generate per block, folded from the block LSB upward.
    always_comb begin
        w_grpP = '0;
        w_grpG = '0;
        for (int b = 0; b < NB; b++) begin
            w_grpP[b] = 1'b1;
            w_grpG[b] = 1'b0;
            for (int i = 0; i < BLOCK; i++) begin
                w_grpG[b] = w_g[b*BLOCK+i] | (w_p[b*BLOCK+i] & w_grpG[b]);
                w_grpP[b] = w_grpP[b] & w_p[b*BLOCK+i];
            end
        end
    end

    // Stage 1 register; a cycle without in_valid loads a bubble and leaves
    // the data registers holding whatever they had.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1Valid <= 1'b0;
            r_s1A     <= '0;
            r_s1B     <= '0;
            r_s1P     <= '0;
            r_s1G     <= '0;
            r_s1Cin   <= 1'b0;
            r_s1GrpP  <= '0;
            r_s1GrpG  <= '0;
        end else begin
            if (in_ready) begin
                r_s1Valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                r_s1A    <= data_operandA;
                r_s1B    <= w_bEff;
                r_s1P    <= w_p;
                r_s1G    <= w_g;
                r_s1Cin  <= w_cinEff;
                r_s1GrpP <= w_grpP;
                r_s1GrpG <= w_grpG;
            end
        end
    end

    // Block carry-ins as a flat sum of products: block k receives the
    // carry-in or any lower block's generate, passed through all the group
    // propagates in between, so no carry ripples from block to block.
    always_comb begin
        w_blkCarry    = '0;
        w_term        = 1'b0;
        w_blkCarry[0] = r_s1Cin;
        for (int k = 1; k <= NB; k++) begin
            w_term = r_s1Cin;
            for (int m = 0; m < k; m++) begin
                w_term = w_term & r_s1GrpP[m];
            end
            w_blkCarry[k] = w_term;
            for (int j = 1; j <= k; j++) begin
                w_term = r_s1GrpG[j-1];
                for (int m = j; m < k; m++) begin
                    w_term = w_term & r_s1GrpP[m];
                end
                w_blkCarry[k] = w_blkCarry[k] | w_term;
            end
        end
    end

    // In-block carries ripple only within a block, seeded by its carry-in.
    always_comb begin
        w_bitCarry = '0;
        for (int b = 0; b < NB; b++) begin
            w_bitCarry[b*BLOCK] = w_blkCarry[b];
            for (int i = 1; i < BLOCK; i++) begin
                w_bitCarry[b*BLOCK+i] = r_s1G[b*BLOCK+i-1] |
                                        (r_s1P[b*BLOCK+i-1] & w_bitCarry[b*BLOCK+i-1]);
            end
        end
    end

    // Overflow compares the carry into the MSB with the MSB's own carry out,
    // which equals the lookahead carryout but stays local to the top block.
    always_comb begin
        w_sumRaw   = r_s1A ^ r_s1B ^ w_bitCarry;
        w_msbCout  = r_s1G[WIDTH-1] | (r_s1P[WIDTH-1] & w_bitCarry[WIDTH-1]);
        w_ovf      = w_bitCarry[WIDTH-1] ^ w_msbCout;
        w_sumFinal = w_sumRaw;
`ifdef PIPE_CLA_SATURATE_EN
        if (w_ovf) begin
            w_sumFinal = r_s1A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Stage 2 register; the result stays put while the consumer stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2Valid <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else if (w_s2Adv) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_sum  <= w_sumFinal;
                r_cout <= w_blkCarry[NB];
                r_ovf  <= w_ovf;
                r_zero <= (w_sumFinal == '0);
            end
        end
    end

    assign out_valid = r_s2Valid;
    assign sum       = r_sum;
    assign carryout  = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipe_cla_addsub
//
// Directed bench for pipe_cla_addsub. A 32-bit/8-bit-block instance covers
// the adder modes, latency, backpressure and mid-flight reset; a
// 16-bit/4-bit-block instance covers the narrow SBC/ADC cases. Expected
// values are hand-computed constants. Clamped expectations follow
// PIPE_CLA_SATURATE_EN when the bench is built with that macro.
// ---------------------------------------------------------------------------
module tb_pipe_cla_addsub;

`ifdef PIPE_CLA_SATURATE_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpAdc = 2'b10;
    localparam logic [1:0] OpSbc = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n;

    // 32-bit instance signals
    logic        inValid;
    logic        inReady;
    logic [1:0]  opSel;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        carryIn;
    logic        outValid;
    logic        outReady;
    logic [31:0] sumOut;
    logic        carryOut;
    logic        overflowOut;
    logic        zeroOut;

    // 16-bit instance signals
    logic        inValid16;
    logic        inReady16;
    logic [1:0]  opSel16;
    logic [15:0] operandA16;
    logic [15:0] operandB16;
    logic        carryIn16;
    logic        outValid16;
    logic        outReady16;
    logic [15:0] sumOut16;
    logic        carryOut16;
    logic        overflowOut16;
    logic        zeroOut16;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clock = ~clock;

    pipe_cla_addsub #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (inValid),
        .in_ready      (inReady),
        .op            (opSel),
        .data_operandA (operandA),
        .data_operandB (operandB),
        .carryin       (carryIn),
        .out_valid     (outValid),
        .out_ready     (outReady),
        .sum           (sumOut),
        .carryout      (carryOut),
        .overflow      (overflowOut),
        .zero          (zeroOut)
    );

    pipe_cla_addsub #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (inValid16),
        .in_ready      (inReady16),
        .op            (opSel16),
        .data_operandA (operandA16),
        .data_operandB (operandB16),
        .carryin       (carryIn16),
        .out_valid     (outValid16),
        .out_ready     (outReady16),
        .sum           (sumOut16),
        .carryout      (carryOut16),
        .overflow      (overflowOut16),
        .zero          (zeroOut16)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one operand set onto the 32-bit instance.
    task automatic applyStimulus(input logic v, input logic [1:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic c);
        inValid  = v;
        opSel    = o;
        operandA = a;
        operandB = b;
        carryIn  = c;
    endtask

    // Drive one operand set onto the 16-bit instance.
    task automatic applyStimulus16(input logic v, input logic [1:0] o,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic c);
        inValid16  = v;
        opSel16    = o;
        operandA16 = a;
        operandB16 = b;
        carryIn16  = c;
    endtask

    // One comparison of an observed value against its required value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Compare all 32-bit result outputs at once.
    task automatic checkResult(input string tag, input logic [31:0] expSum,
                               input logic expCout, input logic expOvf,
                               input logic expZero);
        checkOutput({tag, " out_valid"}, {31'b0, outValid}, 32'd1);
        checkOutput({tag, " sum"}, sumOut, expSum);
        checkOutput({tag, " carryout"}, {31'b0, carryOut}, {31'b0, expCout});
        checkOutput({tag, " overflow"}, {31'b0, overflowOut}, {31'b0, expOvf});
        checkOutput({tag, " zero"}, {31'b0, zeroOut}, {31'b0, expZero});
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset_n    = 1'b0;
        outReady   = 1'b1;
        outReady16 = 1'b1;
        applyStimulus(1'b0, OpAdd, 32'h0, 32'h0, 1'b0);
        applyStimulus16(1'b0, OpAdd, 16'h0, 16'h0, 1'b0);
        #12;
        checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("reset sum", sumOut, 32'd0);
        checkOutput("reset carryout", {31'b0, carryOut}, 32'd0);
        checkOutput("reset overflow", {31'b0, overflowOut}, 32'd0);
        checkOutput("reset zero", {31'b0, zeroOut}, 32'd0);
        checkOutput("reset out_valid16", {31'b0, outValid16}, 32'd0);
        reset_n = 1'b1;
        tick();
        checkOutput("post-reset in_ready", {31'b0, inReady}, 32'd1);

        // ---------------- ADD 0xFF + 1, carryin ignored ----------------
        applyStimulus(1'b1, OpAdd, 32'h0000_00FF, 32'h0000_0001, 1'b1);
        checkOutput("add1 in_ready", {31'b0, inReady}, 32'd1);
        tick();
        applyStimulus(1'b0, OpAdd, 32'h0, 32'h0, 1'b0);
        checkOutput("add1 latency edge1 out_valid", {31'b0, outValid}, 32'd0);
        tick();
        checkResult("add1", 32'h0000_0100, 1'b0, 1'b0, 1'b0);

        // ---------------- ADD 0xFFFFFFFF + 1 ----------------
        applyStimulus(1'b1, OpAdd, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        tick();
        applyStimulus(1'b0, OpAdd, 32'h0, 32'h0, 1'b0);
        checkOutput("add2 bubble out_valid", {31'b0, outValid}, 32'd0);
        tick();
        checkResult("add2", 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // ---------------- SUB 0x80000000 - 1, carryin ignored ----------------
        applyStimulus(1'b1, OpSub, 32'h8000_0000, 32'h0000_0001, 1'b0);
        tick();
        applyStimulus(1'b0, OpAdd, 32'h0, 32'h0, 1'b0);
        tick();
        checkResult("sub1", SatEn ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // ---------------- ADC and SBC on 32 bits ----------------
        applyStimulus(1'b1, OpAdc, 32'h1234_5678, 32'h1111_1111, 1'b1);
        tick();
        applyStimulus(1'b1, OpSbc, 32'h0000_000A, 32'h0000_0003, 1'b1);
        tick();
        checkResult("adc32", 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, OpAdd, 32'h0, 32'h0, 1'b0);
        tick();
        checkResult("sbc32", 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("drain out_valid", {31'b0, outValid}, 32'd0);

        // ---------------- backpressure ----------------
        outReady = 1'b0;
        applyStimulus(1'b1, OpAdd, 32'd1, 32'd1, 1'b0);
        checkOutput("bp accept1 in_ready", {31'b0, inReady}, 32'd1);
        tick();
        applyStimulus(1'b1, OpAdd, 32'd2, 32'd2, 1'b0);
        checkOutput("bp accept2 in_ready", {31'b0, inReady}, 32'd1);
        tick();
        checkOutput("bp r1 out_valid", {31'b0, outValid}, 32'd1);
        checkOutput("bp r1 sum", sumOut, 32'd2);
        applyStimulus(1'b1, OpAdd, 32'd3, 32'd3, 1'b0);
        checkOutput("bp full in_ready", {31'b0, inReady}, 32'd0);
        tick();
        checkOutput("bp stall out_valid", {31'b0, outValid}, 32'd1);
        checkOutput("bp stall sum held", sumOut, 32'd2);
        checkOutput("bp stall in_ready", {31'b0, inReady}, 32'd0);
        outReady = 1'b1;
        #1;
        checkOutput("bp release in_ready", {31'b0, inReady}, 32'd1);
        tick();
        checkOutput("bp r2 sum", sumOut, 32'd4);
        applyStimulus(1'b1, OpAdd, 32'd4, 32'd4, 1'b0);
        tick();
        checkOutput("bp r3 sum", sumOut, 32'd6);
        applyStimulus(1'b0, OpAdd, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("bp r4 out_valid", {31'b0, outValid}, 32'd1);
        checkOutput("bp r4 sum", sumOut, 32'd8);
        tick();
        checkOutput("bp empty out_valid", {31'b0, outValid}, 32'd0);

        // ---------------- reset mid-flight ----------------
        applyStimulus(1'b1, OpAdd, 32'd5, 32'd5, 1'b0);
        tick();
        applyStimulus(1'b1, OpAdd, 32'd6, 32'd6, 1'b0);
        tick();
        checkOutput("rst pre out_valid", {31'b0, outValid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst async out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("rst async sum", sumOut, 32'd0);
        checkOutput("rst async carryout", {31'b0, carryOut}, 32'd0);
        checkOutput("rst async overflow", {31'b0, overflowOut}, 32'd0);
        checkOutput("rst async zero", {31'b0, zeroOut}, 32'd0);
        applyStimulus(1'b1, OpAdd, 32'd7, 32'd7, 1'b0);
        tick();
        checkOutput("rst held out_valid", {31'b0, outValid}, 32'd0);
        applyStimulus(1'b0, OpAdd, 32'h0, 32'h0, 1'b0);
        #3;
        reset_n = 1'b1;
        checkOutput("rst release in_ready", {31'b0, inReady}, 32'd1);
        tick();
        checkOutput("rst after1 out_valid", {31'b0, outValid}, 32'd0);
        tick();
        checkOutput("rst after2 out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("rst after in_ready", {31'b0, inReady}, 32'd1);

        // ---------------- WIDTH=16, BLOCK=4 ----------------
        applyStimulus16(1'b1, OpSbc, 16'h0000, 16'h0001, 1'b0);
        tick();
        applyStimulus16(1'b1, OpAdc, 16'h7FFF, 16'h0000, 1'b1);
        tick();
        checkOutput("sbc16 out_valid", {31'b0, outValid16}, 32'd1);
        checkOutput("sbc16 sum", {16'b0, sumOut16}, 32'h0000_FFFE);
        checkOutput("sbc16 carryout", {31'b0, carryOut16}, 32'd0);
        checkOutput("sbc16 overflow", {31'b0, overflowOut16}, 32'd0);
        applyStimulus16(1'b0, OpAdd, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("adc16 out_valid", {31'b0, outValid16}, 32'd1);
        checkOutput("adc16 sum", {16'b0, sumOut16}, SatEn ? 32'h0000_7FFF : 32'h0000_8000);
        checkOutput("adc16 carryout", {31'b0, carryOut16}, 32'd0);
        checkOutput("adc16 overflow", {31'b0, overflowOut16}, 32'd1);
        checkOutput("adc16 zero", {31'b0, zeroOut16}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
